// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the wb_mux_timeout Wishbone mux.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_UNMAPPED = 2'b01,
        CAUSE_TIMEOUT  = 2'b10,
        CAUSE_SLVERR   = 2'b11
    } cause_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_mux_decode.sv
// Combinational priority address decoder: lowest-index matching window wins.
module wb_mux_decode #(
    parameter int unsigned              NUM_SLAVES = 8,
    parameter logic [32*NUM_SLAVES-1:0] MATCH_ADDR = '0,
    parameter logic [32*NUM_SLAVES-1:0] MATCH_MASK = '0,
    parameter int unsigned              IDX_W      = 3
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan windows upward; the first match locks out the rest
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((adr & MATCH_MASK[32*i +: 32]) == MATCH_ADDR[32*i +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_timeout.sv
// Registered 1-master to N-slave Wishbone classic mux with watchdog timeout
// and error response for unmapped addresses.
// Optional error-capture registers/ports: define WB_MUX_ERR_CAPTURE_EN.
module wb_mux_timeout
    import wb_mux_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES     = 8,
    parameter logic [32*NUM_SLAVES-1:0] MATCH_ADDR     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] MATCH_MASK     = {NUM_SLAVES{32'h0}},
    parameter int unsigned              TIMEOUT_CYCLES = 255,
    parameter int unsigned              TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [31:0]               wbm_adr_i,
    input  logic [31:0]               wbm_dat_i,
    input  logic [3:0]                wbm_sel_i,
    input  logic                      wbm_we_i,
    input  logic                      wbm_cyc_i,
    input  logic                      wbm_stb_i,
    input  logic [2:0]                wbm_cti_i,
    input  logic [1:0]                wbm_bte_i,
    output logic [31:0]               wbm_dat_o,
    output logic                      wbm_ack_o,
    output logic                      wbm_err_o,
    output logic                      wbm_rty_o,
    output logic [32*NUM_SLAVES-1:0]  wbs_adr_o,
    output logic [32*NUM_SLAVES-1:0]  wbs_dat_o,
    output logic [4*NUM_SLAVES-1:0]   wbs_sel_o,
    output logic [NUM_SLAVES-1:0]     wbs_we_o,
    output logic [NUM_SLAVES-1:0]     wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]     wbs_stb_o,
    output logic [3*NUM_SLAVES-1:0]   wbs_cti_o,
    output logic [2*NUM_SLAVES-1:0]   wbs_bte_o,
    input  logic [32*NUM_SLAVES-1:0]  wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]     wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]     wbs_err_i,
    input  logic [NUM_SLAVES-1:0]     wbs_rty_i
`ifdef WB_MUX_ERR_CAPTURE_EN
   ,output logic                      err_valid_o,
    output logic [31:0]               err_adr_o,
    output logic [1:0]                err_cause_o,
    input  logic                      err_clr_i
`endif
);

    localparam int unsigned       IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned       CNT_W    = (TO_W > 0) ? TO_W : 1;
    localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t              state;
    logic [IDX_W-1:0]    sel_q;
    logic [CNT_W-1:0]    cnt;
    logic                ack_q, err_q, rty_q;
    logic [31:0]         dat_q;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                s_ack, s_err, s_rty, s_any;
    logic [31:0]         s_dat;
    logic                req, to_hit;
    logic                ev_unmapped, ev_slverr, ev_timeout;
    logic [NUM_SLAVES-1:0] grant;
    logic                unused_burst;

    wb_mux_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .MATCH_ADDR (MATCH_ADDR),
        .MATCH_MASK (MATCH_MASK),
        .IDX_W      (IDX_W)
    ) u_decode (
        .adr (wbm_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // Burst attributes are dropped: the registered response cannot sustain bursts
    assign unused_burst = ^{wbm_cti_i, wbm_bte_i};

    assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
    assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
    assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
    assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
    assign wbs_cti_o = {NUM_SLAVES{CTI_CLASSIC}};
    assign wbs_bte_o = {NUM_SLAVES{BTE_LINEAR}};

    assign s_ack  = wbs_ack_i[sel_q];
    assign s_err  = wbs_err_i[sel_q];
    assign s_rty  = wbs_rty_i[sel_q];
    assign s_any  = s_ack | s_err | s_rty;
    assign s_dat  = wbs_dat_i[32*sel_q +: 32];
    assign req    = wbm_cyc_i & wbm_stb_i;
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LIMIT);

    assign ev_unmapped = (state == IDLE)   && req && !dec_hit;
    assign ev_slverr   = (state == ACTIVE) && wbm_cyc_i && s_err;
    assign ev_timeout  = (state == ACTIVE) && wbm_cyc_i && !s_any && to_hit;

    // Selected slave follows master cyc combinationally so an abort drops it at once
    always_comb begin
        grant = '0;
        if (state == ACTIVE && wbm_cyc_i) begin
            grant[sel_q] = 1'b1;
        end
    end

    assign wbs_cyc_o = grant;
    assign wbs_stb_o = grant;

    assign wbm_ack_o = ack_q & wbm_cyc_i;
    assign wbm_err_o = err_q & wbm_cyc_i;
    assign wbm_rty_o = rty_q & wbm_cyc_i;
    assign wbm_dat_o = dat_q;

    // Transaction FSM with registered response flags, read data and watchdog
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            sel_q <= '0;
            cnt   <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        if (dec_hit) begin
                            sel_q <= dec_idx;
                            state <= ACTIVE;
                        end else begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                ACTIVE: begin
                    // A slave response on the limit cycle beats the watchdog
                    if (!wbm_cyc_i) begin
                        state <= IDLE;
                    end else if (s_any) begin
                        state <= RESP;
                        if (s_err) begin
                            err_q <= 1'b1;
                        end else if (s_rty) begin
                            rty_q <= 1'b1;
                        end else begin
                            ack_q <= 1'b1;
                            dat_q <= s_dat;
                        end
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_MUX_ERR_CAPTURE_EN
    logic        err_valid_q;
    logic [31:0] err_adr_q;
    cause_t      err_cause_q;

    // Sticky first-error capture; a new error outranks a same-cycle clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            err_valid_q <= 1'b0;
            err_adr_q   <= '0;
            err_cause_q <= CAUSE_NONE;
        end else if ((ev_unmapped || ev_slverr || ev_timeout) && (!err_valid_q || err_clr_i)) begin
            err_valid_q <= 1'b1;
            err_adr_q   <= wbm_adr_i;
            err_cause_q <= ev_unmapped ? CAUSE_UNMAPPED :
                           ev_slverr   ? CAUSE_SLVERR   : CAUSE_TIMEOUT;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_adr_o   = err_adr_q;
    assign err_cause_o = err_cause_q;
`else
    // Error events only steer the FSM; nothing is captured
`endif

endmodule

// File: tb/tb_wb_mux_timeout.sv
// Self-checking bench for wb_mux_timeout (NUM_SLAVES=8, TIMEOUT_CYCLES=16).
module tb_wb_mux_timeout;

    localparam int NS = 8;
    localparam int TO = 16;

    // slave7 .. slave0; slave6 overlaps slave3, slave5 overlaps slave4
    localparam logic [32*NS-1:0] MA = {32'h0000_8000, 32'h0000_1000, 32'h0000_5000, 32'h0000_4000,
                                       32'h0000_1000, 32'h0000_3000, 32'h0000_2000, 32'h0000_0000};
    localparam logic [32*NS-1:0] MM = {32'hFFFF_F800, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_C000,
                                       32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic              wb_clk_i, wb_rst_n_i;
    logic [31:0]       wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic [3:0]        wbm_sel_i;
    logic              wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [2:0]        wbm_cti_i;
    logic [1:0]        wbm_bte_i;
    logic              wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [32*NS-1:0]  wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [4*NS-1:0]   wbs_sel_o;
    logic [NS-1:0]     wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [3*NS-1:0]   wbs_cti_o;
    logic [2*NS-1:0]   wbs_bte_o;
    logic [NS-1:0]     wbs_ack_i, wbs_err_i, wbs_rty_i;
`ifdef WB_MUX_ERR_CAPTURE_EN
    logic              err_valid_o, err_clr_i;
    logic [31:0]       err_adr_o;
    logic [1:0]        err_cause_o;
`endif

    // Slave behaviour: kind 0 ack, 1 err, 2 rty, 3 ack+err, 4 ack+rty, 5 silent
    int          dly  [NS];
    int          kind [NS];
    logic [31:0] sdat [NS];
    int          scnt [NS];
    logic [NS-1:0] force_ack;

    int          checks, errors, xcount;
    logic [31:0] exp_dat;

    wb_mux_timeout #(
        .NUM_SLAVES     (NS),
        .MATCH_ADDR     (MA),
        .MATCH_MASK     (MM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .wbm_adr_i  (wbm_adr_i),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_sel_i  (wbm_sel_i),
        .wbm_we_i   (wbm_we_i),
        .wbm_cyc_i  (wbm_cyc_i),
        .wbm_stb_i  (wbm_stb_i),
        .wbm_cti_i  (wbm_cti_i),
        .wbm_bte_i  (wbm_bte_i),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_o  (wbm_ack_o),
        .wbm_err_o  (wbm_err_o),
        .wbm_rty_o  (wbm_rty_o),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_cti_o  (wbs_cti_o),
        .wbs_bte_o  (wbs_bte_o),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_i  (wbs_ack_i),
        .wbs_err_i  (wbs_err_i),
        .wbs_rty_i  (wbs_rty_i)
`ifdef WB_MUX_ERR_CAPTURE_EN
       ,.err_valid_o (err_valid_o),
        .err_adr_o   (err_adr_o),
        .err_cause_o (err_cause_o),
        .err_clr_i   (err_clr_i)
`endif
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Count consecutive strobe cycles seen by each slave
    always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        for (int i = 0; i < NS; i++) begin
            if (!wb_rst_n_i)      scnt[i] <= 0;
            else if (wbs_stb_o[i]) scnt[i] <= scnt[i] + 1;
            else                  scnt[i] <= 0;
        end
    end

    // Slave responds when its strobe has been held for dly cycles
    always_comb begin
        wbs_ack_i = '0;
        wbs_err_i = '0;
        wbs_rty_i = '0;
        wbs_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            wbs_dat_i[32*i +: 32] = sdat[i];
            if (wbs_stb_o[i] && scnt[i] == dly[i]) begin
                wbs_ack_i[i] = (kind[i] == 0) || (kind[i] == 3) || (kind[i] == 4);
                wbs_err_i[i] = (kind[i] == 1) || (kind[i] == 3);
                wbs_rty_i[i] = (kind[i] == 2) || (kind[i] == 4);
            end
            if (force_ack[i]) wbs_ack_i[i] = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Reference: target = first window hit; unmapped answers after 1 cycle;
    // a slave answering d cycles into ACTIVE gives latency d+2 unless d > TO,
    // in which case the watchdog answers err at TO+2. rk: 0 ack, 1 err, 2 rty.
    function automatic void model(input logic [31:0] adr, input int d, input int k,
                                  output int tgt, output int lat, output int rk);
        tgt = -1;
        for (int i = 0; i < NS; i++)
            if (tgt < 0 && (adr & MM[32*i +: 32]) == MA[32*i +: 32]) tgt = i;
        if (tgt < 0) begin
            lat = 1; rk = 1;
        end else if (k == 5 || d > TO) begin
            lat = TO + 2; rk = 1;
        end else begin
            lat = d + 2;
            rk  = (k == 1 || k == 3) ? 1 : (k == 2 || k == 4) ? 2 : 0;
        end
    endfunction

    task automatic xfer(input logic [31:0] adr, input logic we, input int d, input int k,
                        input logic [31:0] sd, input string tag);
        int tgt, lat, rk, n, bi;
        logic got;
        logic [NS-1:0] onehot;
        logic [2:0] exp_flags;
        model(adr, d, k, tgt, lat, rk);
        onehot = (tgt >= 0) ? NS'(1) << tgt : '0;
        exp_flags = (rk == 0) ? 3'b100 : (rk == 1) ? 3'b010 : 3'b001;
        for (int i = 0; i < NS; i++) begin
            dly[i]  = d;
            kind[i] = k;
            sdat[i] = (i == tgt) ? sd : (~sd ^ 32'(i));
        end
        wbm_adr_i = adr;
        wbm_dat_i = $urandom;
        wbm_sel_i = 4'($urandom);
        wbm_we_i  = we;
        wbm_cti_i = 3'($urandom);
        wbm_bte_i = 2'($urandom);
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        #1;
        bi = xcount % NS;
        check({tag, "_bcast_adr"}, wbs_adr_o[32*bi +: 32], adr);
        check({tag, "_bcast_dat"}, wbs_dat_o[32*bi +: 32], wbm_dat_i);
        check({tag, "_cti_bte"}, {8'h0, wbs_cti_o}, 32'h0);
        check({tag, "_bte"}, {16'h0, wbs_bte_o}, 32'h0);
        xcount++;
        n = 0;
        got = 1'b0;
        while (!got && n < lat + 4) begin
            tick();
            n++;
            if (n == 1) check({tag, "_cyc_c1"}, 32'(wbs_cyc_o), (lat == 1) ? 32'h0 : 32'(onehot));
            if (n == lat - 1 && n > 1) check({tag, "_cyc_pre"}, 32'(wbs_cyc_o), 32'(onehot));
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) got = 1'b1;
        end
        check({tag, "_got"}, 32'(got), 32'h1);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_flags"}, {29'h0, wbm_ack_o, wbm_err_o, wbm_rty_o}, {29'h0, exp_flags});
        check({tag, "_cyc_resp"}, 32'(wbs_cyc_o), 32'h0);
        if (rk == 0) exp_dat = sd;
        check({tag, "_dat"}, wbm_dat_o, exp_dat);
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        tick();
    endtask

    int r, d, k;
    logic [31:0] a;

    initial begin
        checks = 0; errors = 0; xcount = 0; exp_dat = '0;
        force_ack = '0;
        for (int i = 0; i < NS; i++) begin
            dly[i] = 100; kind[i] = 5; sdat[i] = '0;
        end
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_cti_i = '0; wbm_bte_i = '0;
`ifdef WB_MUX_ERR_CAPTURE_EN
        err_clr_i = 1'b0;
`endif
        wb_rst_n_i = 1'b0;
        tick();
        tick();
        check("rst_flags", {29'h0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        check("rst_cyc", 32'(wbs_cyc_o), 32'h0);
        check("rst_stb", 32'(wbs_stb_o), 32'h0);
        wb_rst_n_i = 1'b1;
        tick();

        // Read slave 3 (overlapping slave 6 loses), ack 2 cycles after strobe
        xfer(32'h0000_1040, 1'b0, 2, 0, 32'hDEAD_BEEF, "rd_s3");
        // Unmapped write
        xfer(32'h0000_9000, 1'b1, 0, 0, 32'h1111_2222, "unmapped");
`ifdef WB_MUX_ERR_CAPTURE_EN
        check("cap_valid", 32'(err_valid_o), 32'h1);
        check("cap_cause", 32'(err_cause_o), 32'h1);
        check("cap_adr", err_adr_o, 32'h0000_9000);
`endif
        // Silent slave 0 -> watchdog
        xfer(32'h0000_0010, 1'b0, 100, 5, 32'h3333_4444, "timeout");
`ifdef WB_MUX_ERR_CAPTURE_EN
        check("cap_first_wins", 32'(err_cause_o), 32'h1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("cap_clr", 32'(err_valid_o), 32'h0);
`endif
        xfer(32'h0000_2004, 1'b0, 1, 0, 32'h1234_5678, "after_to");
        xfer(32'h0000_3008, 1'b0, 1, 3, 32'h5555_6666, "ack_err");
        xfer(32'h0000_300C, 1'b0, 0, 4, 32'h7777_8888, "ack_rty");
        xfer(32'h0000_5000, 1'b0, 3, 0, 32'hCAFE_F00D, "overlap_s4");
        xfer(32'h0000_8010, 1'b0, 16, 0, 32'hA5A5_5A5A, "limit_ack");
        xfer(32'h0000_8020, 1'b0, 17, 0, 32'h0F0F_F0F0, "limit_to");

        // Master abort in ACTIVE; late ack must be ignored
        for (int i = 0; i < NS; i++) begin dly[i] = 100; kind[i] = 5; end
        wbm_adr_i = 32'h0000_2000; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        tick();
        check("abort_active", 32'(wbs_cyc_o), 32'h2);
        tick();
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        #1;
        check("abort_drop", 32'(wbs_cyc_o), 32'h0);
        tick();
        wbm_cyc_i = 1'b1;
        force_ack = 8'h02;
        #1;
        check("abort_idle_cyc", 32'(wbs_cyc_o), 32'h0);
        tick();
        check("abort_no_resp1", {29'h0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 32'h0);
        force_ack = '0;
        tick();
        check("abort_no_resp2", {29'h0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 32'h0);
        wbm_cyc_i = 1'b0;
        tick();
        xfer(32'h0000_2000, 1'b0, 0, 0, 32'h0BAD_CAFE, "post_abort");

        // Asynchronous reset in the middle of ACTIVE
        for (int i = 0; i < NS; i++) begin dly[i] = 100; kind[i] = 5; end
        wbm_adr_i = 32'h0000_1040; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        tick();
        tick();
        check("rstmid_active", 32'(wbs_cyc_o), 32'h8);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        check("rstmid_cyc", 32'(wbs_cyc_o), 32'h0);
        check("rstmid_stb", 32'(wbs_stb_o), 32'h0);
        check("rstmid_flags", {29'h0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 32'h0);
        check("rstmid_dat", wbm_dat_o, 32'h0);
        exp_dat = '0;
        wbm_stb_i = 1'b0;
        tick();
        wb_rst_n_i = 1'b1;
        tick();
        check("rstrel_no_resp", {29'h0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 32'h0);
        check("rstrel_cyc", 32'(wbs_cyc_o), 32'h0);
        wbm_cyc_i = 1'b0;
        tick();
        xfer(32'h0000_1044, 1'b0, 1, 0, 32'h600D_F00D, "post_reset");

        // Randomised transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 10);
            if (r <= 9) a = {16'h0, 4'(r), 12'($urandom)};
            else        a = {16'($urandom_range(1, 65535)), 16'($urandom)};
            d = $urandom_range(0, 20);
            k = $urandom_range(0, 5);
            xfer(a, 1'($urandom), d, k, $urandom, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
